output_channel: RTL and testbench
=================================

# output_channel

Per-link output stage of the virtual channel router. It arbitrates round-robin among the five input channels requesting one output link (east, west, north, south or local core) and issues the one-hot grant pulse those channels consume. It then holds the link for the winner until that packet's tailer flit has passed, with wormhole behaviour. It forwards flits to the downstream input FIFO under back-pressure from that FIFO's full flag.

## Interface
Parameters:
- `NPORT`, 5, number of requesting input channels (index 0=east, 1=west, 2=north, 3=south, 4=core)
- `DW`, 32, flit width

Ports:
- `router_clk`, in, 1: single clock for all state.
- `reset`, in, 1: synchronous, active-high.
- `req_in`, in, 5: `req_linkN` / `req_core` of each input channel for this link.
- `valid_in`, in, 5: flit available at channel *i* (that channel's `!fifo_empty`).
- `data_in`, in, 160: flit of channel *i* on bits `[32i+31:32i]` (that channel's `data_to_output_channel`).
- `full_down`, in, 1: downstream input FIFO full.
- `gnt`, out, 5: one-hot grant pulse to input channel *i* (`gnt1..gnt4`, `gnt_c`).
- `rd`, out, 5: one-hot read strobe to the owning channel (`rd1..rd4`, `rd_c`).
- `data_out`, out, 32: registered forwarded flit.
- `out_val`, out, 1: `data_out` valid this cycle; drives downstream `in_val`.
- `busy`, out, 1: link held by a packet.
- `owner`, out, 3: index of current owner; 0 when idle.
- `pkt_count`, out, 8: completed packets, wraps 255→0.

## Operation
- Flit type comes from bits `[30:29]`:
  - header = 01
  - tailer = 10
  - 00 and 11 are body flits.
- FSM states are IDLE, GRANT and XFER.
- **IDLE**
  - If any `req_in` bit is set, pick the winner by round-robin, starting at priority pointer `ptr` and wrapping modulo 5. Go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT** (exactly 1 cycle)
  - `gnt[owner]`=1 for this cycle only.
  - `ptr` ← (owner+1) mod 5.
  - `busy`=1.
  - Go to XFER.
- **XFER**
  - A cycle is a *transfer cycle* when `valid_in[owner]` && `!full_down`.
  - On a transfer cycle: `rd[owner]`=1 (combinational), and `data_in[owner]` is registered into `data_out` with `out_val`=1 on the next cycle.
  - If the transferred flit is a tailer: go to IDLE next cycle, `pkt_count` increments, `busy` drops.
- The owner is held for the whole packet.
  - Deasserting `req_in[owner]` during XFER does not release the link.
  - `req_in` of non-owners is ignored while `busy`.
- `rd` is never asserted outside XFER and never for a non-owner. At most one bit of `rd` or `gnt` is set at any time.
- Reset mid-packet returns to IDLE immediately and drops the partial packet; upstream recovery is not this block's concern.

## Timing
- Reset values:
  - `gnt`=0, `rd`=0, `data_out`=0, `out_val`=0, `busy`=0, `owner`=0, `pkt_count`=0.
  - State is IDLE and `ptr`=0, so east has first priority.
- Latency:
  - `req_in` seen in IDLE at cycle N → `gnt` pulse at N+1.
  - Earliest `rd` at N+2.
  - `data_out`/`out_val` at N+3.
- Throughput is one flit per cycle while `valid_in[owner]`=1 and `full_down`=0.
- Back-pressure:
  - `full_down`=1 in cycle K → `rd`=0 in K and `out_val`=0 in K+1.
  - No flit is lost or duplicated.
- Tailer transferred in cycle T → IDLE at T+1; a new grant is possible at T+2.
  - Requests present at T+1 are arbitrated with the updated `ptr`.
- Empty owner FIFO (`valid_in`=0) stalls in XFER with no timeout.
- Simultaneous requests: the lowest index at or after `ptr` wins.
- `pkt_count` increments in the cycle after the tailer transfer, wrapping 255→0.

## Test plan
- **Reset:** assert `reset` for 2 cycles with all requests set → all outputs 0; first grant after release is `gnt`=00001 (east).
- **Single packet:** `req_in`=00100 with a north packet header/body/body/tailer and `full_down`=0 → `gnt`=00100 one cycle later, then 4 consecutive `rd[2]` pulses. `data_out` shows the 4 flits in order with `out_val` lagging `rd` by 1. Afterwards `busy`=0 and `pkt_count`=1.
- **Round-robin fairness:** all 5 requesting continuously with 2-flit packets → grant order 0,1,2,3,4,0; each channel owns the link exactly once per 5 packets.
- **Back-pressure:** `full_down`=1 for 3 cycles mid-packet → `rd` and `out_val` gap exactly 3 cycles; the received flit sequence is identical to the sent one.
- **Wormhole hold:** during XFER for channel 0, drop `req_in[0]` and raise `req_in[3]` → no `gnt[3]` until after channel 0's tailer is forwarded.
- **Reset mid-packet plus counter wrap:** reset after 2 of 4 flits → IDLE, `out_val`=0, `ptr`=0. Separately, 256 packets → `pkt_count` wraps to 0.

Source files
------------

// File: rtl/output_channel.sv
// Per-link output stage: round-robin arbitration over the input channels,
// wormhole link hold until the tailer passes, registered flit forwarding.
module output_channel #(
  parameter int NPORT = 5,
  parameter int DW    = 32
) (
  input  logic                router_clk,
  input  logic                reset,
  input  logic [NPORT-1:0]    req_in,
  input  logic [NPORT-1:0]    valid_in,
  input  logic [NPORT*DW-1:0] data_in,
  input  logic                full_down,
  output logic [NPORT-1:0]    gnt,
  output logic [NPORT-1:0]    rd,
  output logic [DW-1:0]       data_out,
  output logic                out_val,
  output logic                busy,
  output logic [2:0]          owner,
  output logic [7:0]          pkt_count
);

  typedef enum logic [1:0] {IDLE, GRANT, XFER} state_t;

  state_t      state, state_n;
  logic [2:0]  owner_q;
  logic [2:0]  ptr;
  logic [2:0]  win;
  logic [2:0]  ptr_next;
  logic        any_req;
  logic        xfer;
  logic        is_tail;
  logic [DW-1:0] flit;
  int unsigned k;

  assign flit    = data_in[int'(owner_q)*DW +: DW];
  assign is_tail = (flit[30:29] == 2'b10);
  assign any_req = |req_in;
  assign busy    = (state != IDLE);
  assign owner   = busy ? owner_q : '0;
  assign ptr_next = (owner_q == 3'(NPORT-1)) ? '0 : owner_q + 3'd1;

  // Scan from the farthest offset down to ptr so the nearest requester wins.
  always_comb begin
    win = ptr;
    k   = 0;
    for (int unsigned i = NPORT; i > 0; i--) begin
      k = 32'(ptr) + i - 1;
      if (k >= NPORT) k = k - NPORT;
      if (req_in[k[2:0]]) win = k[2:0];
    end
  end

  always_ff @(posedge router_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    gnt     = '0;
    rd      = '0;
    xfer    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_n = GRANT;
      end
      GRANT: begin
        gnt[owner_q] = 1'b1;
        state_n      = XFER;
      end
      XFER: begin
        xfer = valid_in[owner_q] && !full_down;
        if (xfer) begin
          rd[owner_q] = 1'b1;
          if (is_tail) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge router_clk) begin
    if (reset) begin
      owner_q   <= '0;
      ptr       <= '0;
      data_out  <= '0;
      out_val   <= 1'b0;
      pkt_count <= '0;
    end else begin
      out_val <= xfer;
      if (xfer) data_out <= flit;
      if (state == IDLE && any_req) owner_q <= win;
      if (state == GRANT) ptr <= ptr_next;
      if (xfer && is_tail) pkt_count <= pkt_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_output_channel.sv
// Bench for output_channel: upstream FIFO models feed the DUT, a scoreboard
// queue holds expected flits and a negedge monitor checks everything forwarded.
module tb_output_channel;
  localparam int NP = 5;
  localparam int W  = 32;

  logic            router_clk = 1'b0;
  logic            reset = 1'b1;
  logic [NP-1:0]   req_in;
  logic [NP-1:0]   valid_vec = '0;
  logic [NP*W-1:0] data_bus = '0;
  logic            full_down = 1'b0;
  logic [NP-1:0]   gnt, rd;
  logic [W-1:0]    data_out;
  logic            out_val, busy;
  logic [2:0]      owner;
  logic [7:0]      pkt_count;

  logic [W-1:0]  fifo [NP][$];
  logic [W-1:0]  exp_q [$];
  logic          auto_req = 1'b1;
  logic [NP-1:0] req_extra = '0;
  int checks = 0, errors = 0, cyc = 0;
  int gnt_idx [$];
  int gnt_cyc [$];
  int tail_cyc [$];
  int first_out = -1, last_out = -1, n_out = 0;
  int rd_cnt [NP];
  logic [NP-1:0] prev_rd = '0, rd_seen = '0;
  logic prev_reset = 1'b1;

  assign req_in = (auto_req ? valid_vec : '0) | req_extra;

  always #5 router_clk = ~router_clk;
  always @(posedge router_clk) cyc++;

  output_channel #(.NPORT(NP), .DW(W)) dut (
    .router_clk(router_clk), .reset(reset), .req_in(req_in),
    .valid_in(valid_vec), .data_in(data_bus), .full_down(full_down),
    .gnt(gnt), .rd(rd), .data_out(data_out), .out_val(out_val),
    .busy(busy), .owner(owner), .pkt_count(pkt_count)
  );

  function automatic logic [W-1:0] mk(input logic [1:0] t, input int ch, input int seq);
    logic [31:0] c, s;
    c = ch;
    s = seq;
    return {1'b0, t, c[4:0], s[23:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NP; i++) begin
      valid_vec[i] = (fifo[i].size() != 0);
      data_bus[i*W +: W] = (fifo[i].size() != 0) ? fifo[i][0] : '0;
    end
  endtask

  task automatic push(input int ch, input logic [W-1:0] f, input bit expect_out);
    fifo[ch].push_back(f);
    if (expect_out) exp_q.push_back(f);
    refresh();
  endtask

  task automatic step();
    @(posedge router_clk);
    #1;
  endtask

  task automatic clear_logs();
    gnt_idx.delete();
    gnt_cyc.delete();
    tail_cyc.delete();
    first_out = -1;
    last_out  = -1;
    n_out     = 0;
    for (int i = 0; i < NP; i++) rd_cnt[i] = 0;
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b1;
    full_down = 1'b0;
    auto_req  = 1'b1;
    req_extra = '0;
    for (int i = 0; i < NP; i++) fifo[i].delete();
    exp_q.delete();
    refresh();
    repeat (n) step();
    clear_logs();
    reset = 1'b0;
  endtask

  task automatic wait_gnt(output int idx, output int c, output logic [NP-1:0] gv);
    bit found;
    found = 0;
    idx = -1;
    c = -1;
    gv = '0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge router_clk);
      if (gnt != '0) begin
        found = 1;
        gv = gnt;
        c = cyc;
        for (int i = 0; i < NP; i++) if (gnt[i]) idx = i;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL gnt_timeout: got no grant, required a grant within 60 cycles");
    end
  endtask

  task automatic wait_drain(input int maxc);
    bit done;
    done = 0;
    for (int n = 0; n < maxc && !done; n++) begin
      @(negedge router_clk);
      if (exp_q.size() == 0) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d flits still expected, required 0", exp_q.size());
    end
  endtask

  // Upstream FIFOs: pop on the read strobe seen during the cycle.
  initial begin
    forever begin
      @(negedge router_clk);
      rd_seen = rd;
      @(posedge router_clk);
      #1;
      for (int i = 0; i < NP; i++)
        if (rd_seen[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
      refresh();
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [W-1:0] e;
    logic bad;
    forever begin
      @(negedge router_clk);
      check("out_val_lag", {31'b0, out_val}, {31'b0, (|prev_rd) && !prev_reset});
      if (out_val) begin
        n_out++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_flit: got %0h, required no flit", data_out);
        end else begin
          e = exp_q.pop_front();
          check("flit", data_out, e);
        end
        if (data_out[30:29] == 2'b10) tail_cyc.push_back(cyc);
      end
      bad = !$onehot0(rd) || ((rd & ~valid_vec) != '0) ||
            (full_down && rd != '0) || (!busy && rd != '0);
      check("rd_legal", {31'b0, bad}, 32'd0);
      check("gnt_onehot", {31'b0, $onehot0(gnt)}, 32'd1);
      for (int i = 0; i < NP; i++) begin
        if (gnt[i]) begin
          gnt_idx.push_back(i);
          gnt_cyc.push_back(cyc);
        end
        if (rd[i]) rd_cnt[i]++;
      end
      prev_rd    = rd;
      prev_reset = reset;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1ms, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, gc, p;
    logic [NP-1:0] gv;

    // Reset with every request asserted
    reset = 1'b1;
    req_extra = '1;
    step();
    @(negedge router_clk);
    check("rst_gnt", {27'b0, gnt}, 32'd0);
    check("rst_rd", {27'b0, rd}, 32'd0);
    check("rst_data_out", data_out, 32'd0);
    check("rst_out_val", {31'b0, out_val}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_owner", {29'b0, owner}, 32'd0);
    check("rst_pkt_count", {24'b0, pkt_count}, 32'd0);
    step();
    clear_logs();
    reset = 1'b0;
    p = cyc;
    wait_gnt(idx, gc, gv);
    check("first_gnt", {27'b0, gv}, 32'b00001);
    check("first_gnt_latency", gc, p + 1);

    // Single north packet
    do_reset(2);
    p = cyc;
    push(2, mk(2'b01, 2, 0), 1);
    push(2, mk(2'b00, 2, 1), 1);
    push(2, mk(2'b11, 2, 2), 1);
    push(2, mk(2'b10, 2, 3), 1);
    wait_gnt(idx, gc, gv);
    check("single_gnt", {27'b0, gv}, 32'b00100);
    check("single_gnt_latency", gc, p + 1);
    wait_drain(40);
    check("single_first_out", first_out, gc + 2);
    check("single_n_out", n_out, 4);
    check("single_back_to_back", last_out - first_out, 3);
    check("single_rd_count", rd_cnt[2], 4);
    check("single_busy_after", {31'b0, busy}, 32'd0);
    check("single_pkt_count", {24'b0, pkt_count}, 32'd1);

    // Round-robin: every channel with two 2-flit packets
    do_reset(2);
    for (int pk = 0; pk < 2; pk++)
      for (int ch = 0; ch < NP; ch++) begin
        push(ch, mk(2'b01, ch, 2*pk), 1);
        push(ch, mk(2'b10, ch, 2*pk+1), 1);
      end
    wait_drain(200);
    check("rr_grant_count", gnt_idx.size(), 10);
    for (int k2 = 0; k2 < 10 && k2 < gnt_idx.size(); k2++)
      check("rr_order", gnt_idx[k2], k2 % NP);
    check("rr_pkt_count", {24'b0, pkt_count}, 32'd10);

    // Back-pressure: three full cycles mid-packet
    do_reset(2);
    push(1, mk(2'b01, 1, 0), 1);
    for (int s = 1; s < 5; s++) push(1, mk(2'(s % 4 == 1 ? 0 : 3), 1, s), 1);
    push(1, mk(2'b10, 1, 5), 1);
    wait_gnt(idx, gc, gv);
    check("bp_gnt", {27'b0, gv}, 32'b00010);
    step();
    step();
    full_down = 1'b1;
    repeat (3) step();
    full_down = 1'b0;
    wait_drain(60);
    check("bp_n_out", n_out, 6);
    check("bp_gap", (last_out - first_out + 1) - n_out, 3);
    check("bp_rd_count", rd_cnt[1], 6);

    // Wormhole hold: east drops its request, south raises one
    do_reset(2);
    auto_req = 1'b0;
    req_extra = 5'b00001;
    for (int s = 0; s < 4; s++) push(0, mk(s == 0 ? 2'b01 : (s == 3 ? 2'b10 : 2'b00), 0, s), 1);
    push(3, mk(2'b01, 3, 0), 1);
    push(3, mk(2'b10, 3, 1), 1);
    wait_gnt(idx, gc, gv);
    check("wh_first_gnt", {27'b0, gv}, 32'b00001);
    step();
    req_extra = 5'b01000;
    wait_drain(60);
    check("wh_grant_count_ge2", {31'b0, gnt_idx.size() >= 2}, 32'd1);
    if (gnt_idx.size() >= 2 && tail_cyc.size() >= 1) begin
      check("wh_second_owner", gnt_idx[1], 3);
      check("wh_gnt_after_tail", gnt_cyc[1], tail_cyc[0] + 1);
    end

    // Reset after two of four flits
    do_reset(2);
    push(2, mk(2'b01, 2, 0), 1);
    push(2, mk(2'b00, 2, 1), 1);
    push(2, mk(2'b00, 2, 2), 0);
    push(2, mk(2'b10, 2, 3), 0);
    wait_gnt(idx, gc, gv);
    step();
    step();
    step();
    reset = 1'b1;
    full_down = 1'b1;
    step();
    for (int i = 0; i < NP; i++) fifo[i].delete();
    refresh();
    full_down = 1'b0;
    reset = 1'b0;
    @(negedge router_clk);
    check("mid_rst_out_val", {31'b0, out_val}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_owner", {29'b0, owner}, 32'd0);
    check("mid_rst_pkt_count", {24'b0, pkt_count}, 32'd0);
    check("mid_rst_partial", exp_q.size(), 0);
    check("mid_rst_n_out", n_out, 2);
    step();
    clear_logs();
    push(3, mk(2'b10, 3, 9), 0);
    push(0, mk(2'b10, 0, 9), 1);
    exp_q.push_back(mk(2'b10, 3, 9));
    wait_drain(40);
    if (gnt_idx.size() >= 1) check("mid_rst_ptr_east_first", gnt_idx[0], 0);
    else check("mid_rst_ptr_east_first", 32'hFFFF_FFFF, 0);

    // Packet counter wrap
    do_reset(2);
    for (int s = 0; s < 255; s++) push(0, mk(2'b10, 0, s), 1);
    wait_drain(1000);
    check("cnt_255", {24'b0, pkt_count}, 32'd255);
    push(0, mk(2'b10, 0, 255), 1);
    wait_drain(20);
    check("cnt_wrap", {24'b0, pkt_count}, 32'd0);

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
